// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit-path CRC-16 sequencing logic.
package usb_tx_pkg;

  localparam int MAX_BYTES_DEF = 64;
  localparam int CNT_W_DEF     = 7;

  // Engine preset value, and what the engine reports while held in preset.
  localparam logic [15:0] CRC16_PRESET = 16'hFFFF;
  localparam logic [15:0] CRC16_EMPTY  = 16'h0000;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SHIFT     = 3'd1,
    ST_EMIT      = 3'd2,
    ST_WAIT_BYTE = 3'd3,
    ST_CRC_LO    = 3'd4,
    ST_CRC_HI    = 3'd5
  } crc_seq_state_t;

endpackage

// File: rtl/CDL_CRC_16.sv
// Serial USB CRC-16 engine (x^16 + x^15 + x^2 + 1), data consumed LSB-first.
// Kept in reflected form: register bit 0 is the oldest CRC bit, so
// inverted_crc[7:0] is the first CRC byte on the wire.
module CDL_CRC_16
  import usb_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        reset_crc,
  input  logic        enable,
  input  logic        input_data,
  output logic [15:0] inverted_crc
);

  logic [15:0] crc_q;
  logic [15:0] crc_d;
  logic        fb;

  // Preset has priority; otherwise shift one bit when enabled.
  always_comb begin
    fb    = input_data ^ crc_q[0];
    crc_d = crc_q;
    if (reset_crc) begin
      crc_d = CRC16_PRESET;
    end else if (enable) begin
      crc_d = {1'b0, crc_q[15:1]} ^ (fb ? 16'hA001 : 16'h0000);
    end
  end

  // CRC register, preset on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q <= CRC16_PRESET;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign inverted_crc = ~crc_q;

endmodule

// File: rtl/crc16_bit_shifter.sv
// Byte latch plus 3-bit bit counter that feeds one byte LSB-first to the
// serial CRC engine while shift_i is held; done_o marks the eighth bit.
module crc16_bit_shifter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       load_i,
  input  logic [7:0] byte_i,
  input  logic       shift_i,
  output logic [7:0] byte_o,
  output logic       crc_bit_o,
  output logic       crc_enable_o,
  output logic       done_o
);

  logic [7:0] byte_q;
  logic [2:0] bit_cnt_q;

  // Latch the byte on load; step the bit counter on every shift, wrapping
  // back to 0 after bit 7 so the next byte starts clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_q    <= 8'h00;
      bit_cnt_q <= 3'd0;
    end else begin
      if (load_i) begin
        byte_q <= byte_i;
      end
      if (clear_i) begin
        bit_cnt_q <= 3'd0;
      end else if (shift_i) begin
        bit_cnt_q <= bit_cnt_q + 3'd1;
      end
    end
  end

  assign byte_o       = byte_q;
  assign crc_enable_o = shift_i;
  assign crc_bit_o    = shift_i & byte_q[bit_cnt_q];
  assign done_o       = shift_i & (bit_cnt_q == 3'd7);

endmodule

// File: rtl/crc16_tx_sequencer.sv
// Transmit sequencer: accepts payload bytes, shifts each through the external
// serial CRC-16 engine, forwards the byte, then appends the two CRC bytes.
// Handles zero-length packets, abort and payload overrun.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. A producer holds its data stable while valid=1 and ready=0, and
// ready never depends combinationally on the other side's valid/ready
// (in_ready_o is a function of state, rst, abort_i and zlp_req_i only).
module crc16_tx_sequencer
  import usb_tx_pkg::*;
#(
  parameter int MAX_BYTES = MAX_BYTES_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [7:0]     in_data_i,
  input  logic           in_valid_i,
  input  logic           in_last_i,
  output logic           in_ready_o,
  input  logic           zlp_req_i,
  input  logic           abort_i,
  output logic [7:0]     out_data_o,
  output logic           out_valid_o,
  input  logic           out_ready_i,
  output logic           out_is_crc_o,
  output logic           out_last_o,
  output logic           crc_reset_o,
  output logic           crc_enable_o,
  output logic           crc_bit_o,
  input  logic [15:0]    crc_value_i,
  output logic           busy_o,
  output logic           overrun_err_o,
  output crc_seq_state_t dbg_state_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);

  crc_seq_state_t   state_q, state_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic             last_q, last_d;
  logic [15:0]      crc_q, crc_d;
  logic             overrun_q, overrun_d;

  logic             in_fire;
  logic             out_fire;
  logic             overrun_hit;
  logic             sh_shift;
  logic             sh_load;
  logic             sh_done;
  logic [7:0]       sh_byte;

  assign in_fire     = in_valid_i & in_ready_o;
  assign out_fire    = out_valid_o & out_ready_i;
  // A byte arriving after MAX_BYTES have been taken is swallowed, not shifted.
  assign overrun_hit = (state_q == ST_WAIT_BYTE) && in_fire && (byte_cnt_q == MAX_CNT);
  assign sh_shift    = (state_q == ST_SHIFT) && !abort_i;
  assign sh_load     = in_fire && !overrun_hit;

  crc16_bit_shifter u_shifter (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (abort_i),
    .load_i       (sh_load),
    .byte_i       (in_data_i),
    .shift_i      (sh_shift),
    .byte_o       (sh_byte),
    .crc_bit_o    (crc_bit_o),
    .crc_enable_o (crc_enable_o),
    .done_o       (sh_done)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides every other event.
  always_comb begin
    state_d = state_q;
    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (zlp_req_i)       state_d = ST_CRC_LO;
          else if (in_valid_i) state_d = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (sh_done) state_d = ST_EMIT;
        end
        ST_EMIT: begin
          if (out_ready_i) state_d = last_q ? ST_CRC_LO : ST_WAIT_BYTE;
        end
        ST_WAIT_BYTE: begin
          if (in_valid_i) state_d = overrun_hit ? ST_CRC_LO : ST_SHIFT;
        end
        ST_CRC_LO: begin
          if (out_ready_i) state_d = ST_CRC_HI;
        end
        ST_CRC_HI: begin
          if (out_ready_i) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs decoded from the current state; abort blanks the out side and
  // presets the engine in the same cycle.
  always_comb begin
    in_ready_o   = 1'b0;
    out_valid_o  = 1'b0;
    out_data_o   = 8'h00;
    out_is_crc_o = 1'b0;
    out_last_o   = 1'b0;
    crc_reset_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready_o  = !rst && !zlp_req_i;
        crc_reset_o = 1'b1;
      end
      ST_EMIT: begin
        out_valid_o = 1'b1;
        out_data_o  = sh_byte;
      end
      ST_WAIT_BYTE: begin
        in_ready_o = 1'b1;
      end
      ST_CRC_LO: begin
        out_valid_o  = 1'b1;
        out_is_crc_o = 1'b1;
        out_data_o   = crc_q[7:0];
      end
      ST_CRC_HI: begin
        out_valid_o  = 1'b1;
        out_is_crc_o = 1'b1;
        out_last_o   = 1'b1;
        out_data_o   = crc_q[15:8];
      end
      default: ;
    endcase
    if (abort_i) begin
      in_ready_o   = 1'b0;
      out_valid_o  = 1'b0;
      out_data_o   = 8'h00;
      out_is_crc_o = 1'b0;
      out_last_o   = 1'b0;
      crc_reset_o  = 1'b1;
    end
  end

  // Packet bookkeeping: byte count, last flag, captured CRC, overrun flag.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    last_d     = last_q;
    crc_d      = crc_q;
    overrun_d  = overrun_q;
    if (abort_i) begin
      byte_cnt_d = '0;
      last_d     = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (zlp_req_i) begin
            // Engine is held in preset here, so this captures the empty CRC.
            crc_d      = crc_value_i;
            overrun_d  = 1'b0;
            byte_cnt_d = '0;
            last_d     = 1'b0;
          end else if (in_fire) begin
            byte_cnt_d = CNT_W'(1);
            last_d     = in_last_i;
            overrun_d  = 1'b0;
          end
        end
        ST_EMIT: begin
          if (out_fire && last_q) crc_d = crc_value_i;
        end
        ST_WAIT_BYTE: begin
          if (in_fire) begin
            if (overrun_hit) begin
              overrun_d = 1'b1;
              last_d    = 1'b1;
              crc_d     = crc_value_i;
            end else begin
              byte_cnt_d = byte_cnt_q + CNT_W'(1);
              last_d     = in_last_i;
            end
          end
        end
        ST_CRC_HI: begin
          if (out_fire) begin
            byte_cnt_d = '0;
            last_d     = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_q <= '0;
      last_q     <= 1'b0;
      crc_q      <= CRC16_EMPTY;
      overrun_q  <= 1'b0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      last_q     <= last_d;
      crc_q      <= crc_d;
      overrun_q  <= overrun_d;
    end
  end

  assign busy_o        = (state_q != ST_IDLE);
  assign overrun_err_o = overrun_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_crc16_tx_sequencer.sv
// Bench for crc16_tx_sequencer with the serial CRC engine wired beside it.
module tb_crc16_tx_sequencer;
  import usb_tx_pkg::*;

  localparam int BUDGET = 2000;

  logic           clk;
  logic           rst;
  logic [7:0]     in_data;
  logic           in_valid;
  logic           in_last;
  logic           in_ready;
  logic           zlp_req;
  logic           abort;
  logic [7:0]     out_data;
  logic           out_valid;
  logic           out_ready;
  logic           out_is_crc;
  logic           out_last;
  logic           crc_reset;
  logic           crc_enable;
  logic           crc_bit;
  logic [15:0]    crc_value;
  logic           busy;
  logic           overrun_err;
  crc_seq_state_t dbg_state;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  crc16_tx_sequencer #(.MAX_BYTES(64), .CNT_W(7)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_data_i     (in_data),
    .in_valid_i    (in_valid),
    .in_last_i     (in_last),
    .in_ready_o    (in_ready),
    .zlp_req_i     (zlp_req),
    .abort_i       (abort),
    .out_data_o    (out_data),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_is_crc_o  (out_is_crc),
    .out_last_o    (out_last),
    .crc_reset_o   (crc_reset),
    .crc_enable_o  (crc_enable),
    .crc_bit_o     (crc_bit),
    .crc_value_i   (crc_value),
    .busy_o        (busy),
    .overrun_err_o (overrun_err),
    .dbg_state_o   (dbg_state)
  );

  CDL_CRC_16 u_engine (
    .clk          (clk),
    .rst          (rst),
    .reset_crc    (crc_reset),
    .enable       (crc_enable),
    .input_data   (crc_bit),
    .inverted_crc (crc_value)
  );

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  int          en_cnt = 0;
  logic [9:0]  exp_q[$];
  logic [7:0]  pkt[$];
  logic        stall_prev;
  logic [9:0]  prev_word;
  logic [9:0]  out_word;

  assign out_word = {out_is_crc, out_last, out_data};

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // USB CRC-16 in the textbook MSB-first form; the wire value is the
  // bit-reversed complement of the register.
  function automatic logic [15:0] crc16_model(input int n);
    logic [15:0] r;
    logic [15:0] rev;
    logic        fb;
    r = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 8; j++) begin
        fb = r[15] ^ pkt[i][j];
        r  = {r[14:0], 1'b0};
        if (fb) r = r ^ 16'h8005;
      end
    end
    for (int k = 0; k < 16; k++) rev[k] = r[15-k];
    return ~rev;
  endfunction

  task automatic push_expected(input int n);
    logic [15:0] c;
    for (int i = 0; i < n; i++) exp_q.push_back({2'b00, pkt[i]});
    c = crc16_model(n);
    exp_q.push_back({2'b10, c[7:0]});
    exp_q.push_back({2'b11, c[15:8]});
  endtask

  // Output monitor: pop on every out handshake, check hold stability and
  // engine control exclusivity.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev <= 1'b0;
    end else begin
      if (crc_enable) begin
        en_cnt <= en_cnt + 1;
        check("crc_excl", {31'd0, crc_reset}, 32'd0);
      end
      if (stall_prev && out_valid) check("hold_stable", {22'd0, out_word}, {22'd0, prev_word});
      stall_prev <= out_valid && !out_ready;
      prev_word  <= out_word;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("sb_unexpected", 32'(exp_q.size()), 32'd1);
        else check("out_word", {22'd0, out_word}, {22'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input logic l);
    int n;
    n = 0;
    @(negedge clk);
    in_data = b; in_last = l; in_valid = 1'b1;
    #1;
    while (!in_ready && n < BUDGET) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= BUDGET) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic send_pkt(input logic mark_last);
    for (int i = 0; i < pkt.size(); i++) send_byte(pkt[i], mark_last && (i == pkt.size() - 1));
  endtask

  task automatic wait_state(input string tag, input crc_seq_state_t s);
    int n;
    n = 0;
    while (dbg_state !== s && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(dbg_state), 32'(s));
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    #1;
    check(tag, {31'd0, busy}, 32'd0);
    check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic stall_then_pulse();
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  int e0;

  initial begin
    rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0;
    zlp_req = 1'b0; abort = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_is_crc", {31'd0, out_is_crc}, 32'd0);
    check("rst_last", {31'd0, out_last}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_crc_reset", {31'd0, crc_reset}, 32'd1);
    check("rst_crc_enable", {31'd0, crc_enable}, 32'd0);
    check("rst_crc_bit", {31'd0, crc_bit}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overrun", {31'd0, overrun_err}, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(posedge clk); #1 rst = 1'b0;

    // Basic two-byte packet, free-flowing output.
    out_ready = 1'b1;
    pkt = '{8'h33, 8'hCC};
    e0 = en_cnt;
    push_expected(2);
    send_pkt(1'b1);
    wait_idle("t1_idle");
    check("t1_crc_enables", 32'(en_cnt - e0), 32'd16);

    // Random short packets.
    for (int p = 0; p < 3; p++) begin
      pkt.delete();
      for (int i = 0; i < $urandom_range(1, 8); i++) pkt.push_back(8'($urandom_range(0, 255)));
      push_expected(pkt.size());
      send_pkt(1'b1);
      wait_idle("t2_idle");
    end

    // Zero-length packet: CRC bytes only, engine never enabled.
    pkt.delete();
    e0 = en_cnt;
    push_expected(0);
    @(negedge clk); zlp_req = 1'b1;
    @(posedge clk); #1 zlp_req = 1'b0;
    check("t3_zlp_state", 32'(dbg_state), 32'(ST_CRC_LO));
    wait_idle("t3_idle");
    check("t3_crc_enables", 32'(en_cnt - e0), 32'd0);

    // zlp_req wins over a simultaneous byte.
    push_expected(0);
    @(negedge clk); zlp_req = 1'b1; in_valid = 1'b1; in_data = 8'h5A; in_last = 1'b1;
    #1 check("t3b_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1 zlp_req = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    check("t3b_state", 32'(dbg_state), 32'(ST_CRC_LO));
    wait_idle("t3b_idle");

    // Backpressure in EMIT and CRC_LO.
    out_ready = 1'b0;
    pkt = '{8'h33, 8'hCC};
    push_expected(2);
    send_byte(8'h33, 1'b0);
    wait_state("t4_emit0", ST_EMIT);
    stall_then_pulse();
    send_byte(8'hCC, 1'b1);
    wait_state("t4_emit1", ST_EMIT);
    stall_then_pulse();
    wait_state("t4_crc_lo", ST_CRC_LO);
    stall_then_pulse();
    out_ready = 1'b1;
    wait_idle("t4_idle");

    // Overrun: 65 bytes without last; 64 forwarded, CRC over those 64.
    pkt.delete();
    for (int i = 0; i < 65; i++) pkt.push_back(8'($urandom_range(0, 255)));
    push_expected(64);
    send_pkt(1'b0);
    check("t5_overrun_set", {31'd0, overrun_err}, 32'd1);
    check("t5_state", 32'(dbg_state), 32'(ST_CRC_LO));
    wait_idle("t5_idle");
    check("t5_overrun_sticky", {31'd0, overrun_err}, 32'd1);

    // Abort on the 4th SHIFT cycle of byte 2; first byte clears overrun.
    exp_q.push_back({2'b00, 8'h11});
    send_byte(8'h11, 1'b0);
    check("t6_overrun_clr", {31'd0, overrun_err}, 32'd0);
    send_byte(8'h22, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("t6_in_shift", 32'(dbg_state), 32'(ST_SHIFT));
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check("t6_abort_state", 32'(dbg_state), 32'(ST_IDLE));
    check("t6_abort_valid", {31'd0, out_valid}, 32'd0);
    check("t6_abort_crc_reset", {31'd0, crc_reset}, 32'd1);
    check("t6_abort_busy", {31'd0, busy}, 32'd0);
    pkt = '{8'h33, 8'hCC};
    push_expected(2);
    send_pkt(1'b1);
    wait_idle("t6_idle");

    // Reset while in CRC_LO: no CRC byte may come out.
    out_ready = 1'b0;
    exp_q.push_back({2'b00, 8'h33});
    exp_q.push_back({2'b00, 8'hCC});
    send_byte(8'h33, 1'b0);
    wait_state("t7_emit0", ST_EMIT);
    stall_then_pulse();
    send_byte(8'hCC, 1'b1);
    wait_state("t7_emit1", ST_EMIT);
    stall_then_pulse();
    wait_state("t7_crc_lo", ST_CRC_LO);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check("t7_valid", {31'd0, out_valid}, 32'd0);
    check("t7_data", {24'd0, out_data}, 32'd0);
    check("t7_is_crc", {31'd0, out_is_crc}, 32'd0);
    check("t7_busy", {31'd0, busy}, 32'd0);
    check("t7_crc_reset", {31'd0, crc_reset}, 32'd1);
    check("t7_in_ready", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    wait_idle("t7_idle");

    // Recovery packet after reset.
    pkt = '{8'h33, 8'hCC};
    push_expected(2);
    send_pkt(1'b1);
    wait_idle("t8_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
